// File: rtl/multicycle_ctrl_if.sv
// Clock/reset bundle shared by the multicycle controller and its environment.
interface ctrl_bus_if;
  logic clk;
  logic reset;

  modport central (
    input clk,
    input reset
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore FSM controller for a multicycle MIPS-subset datapath
// (lw, sw, R-type, beq, addi, j), with per-instruction retire strobe.
module multicycle_ctrl (
  ctrl_bus_if.central ctrl_bus,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       i_or_d,
  output logic       ireg_enab,
  output logic       pc_enab,
  output logic       pc_src,
  output logic       alu_srcA,
  output logic [1:0] alu_srcB,
  output logic [2:0] alu_ctrl_sig,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       jmp,
  output logic       mem_write,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_reg, state_next;
  logic   illegal_reg;
  logic   op_supported;
  logic   pc_write, branch;
  logic   ireg_raw, reg_write_raw, mem_write_raw;

  assign op_supported = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                        (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

  always_ff @(posedge ctrl_bus.clk) begin
    if (ctrl_bus.reset) begin
      state_reg   <= FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE && !op_supported)
        illegal_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:   state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JEX;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_next = MEMWB;
      RTYPEEX: state_next = RTYPEWB;
      ADDIEX:  state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    i_or_d        = 1'b0;
    ireg_raw      = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    pc_src        = 1'b0;
    alu_srcA      = 1'b0;
    alu_srcB      = 2'b00;
    alu_ctrl_sig  = 3'b010;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write_raw = 1'b0;
    jmp           = 1'b0;
    mem_write_raw = 1'b0;
    retire        = 1'b0;
    case (state_reg)
      FETCH: begin
        ireg_raw = 1'b1;
        pc_write = 1'b1;
        alu_srcB = 2'b01;
      end
      DECODE: begin
        alu_srcB = 2'b11;
        retire   = !op_supported;
      end
      MEMADR: begin
        alu_srcA = 1'b1;
        alu_srcB = 2'b10;
      end
      MEMRD: i_or_d = 1'b1;
      MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      MEMWR: begin
        i_or_d        = 1'b1;
        mem_write_raw = 1'b1;
        retire        = 1'b1;
      end
      RTYPEEX: begin
        alu_srcA = 1'b1;
        case (funct)
          6'b100010: alu_ctrl_sig = 3'b110;
          6'b100100: alu_ctrl_sig = 3'b000;
          6'b100101: alu_ctrl_sig = 3'b001;
          6'b101010: alu_ctrl_sig = 3'b111;
          default:   alu_ctrl_sig = 3'b010;
        endcase
      end
      RTYPEWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      BEQEX: begin
        alu_srcA     = 1'b1;
        alu_ctrl_sig = 3'b110;
        pc_src       = 1'b1;
        branch       = 1'b1;
        retire       = 1'b1;
      end
      ADDIEX: begin
        alu_srcA = 1'b1;
        alu_srcB = 2'b10;
      end
      ADDIWB: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      JEX: begin
        jmp      = 1'b1;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes are gated by reset so an abandoned instruction never commits.
  assign pc_enab    = (pc_write | (branch & zero)) & ~ctrl_bus.reset;
  assign ireg_enab  = ireg_raw & ~ctrl_bus.reset;
  assign reg_write  = reg_write_raw & ~ctrl_bus.reset;
  assign mem_write  = mem_write_raw & ~ctrl_bus.reset;
  assign state      = state_reg;
  assign illegal_op = illegal_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against an
// instruction-level reference model (state walk, latency, per-state outputs).
module tb_multicycle_ctrl;

  ctrl_bus_if bus ();

  logic [5:0]  op, funct;
  logic        zero;
  logic        i_or_d, ireg_enab, pc_enab, pc_src, alu_srcA;
  logic [1:0]  alu_srcB;
  logic [2:0]  alu_ctrl_sig;
  logic        reg_dst, mem_to_reg, reg_write, jmp, mem_write;
  logic [3:0]  state;
  logic        retire, illegal_op;

  int checks = 0;
  int failures = 0;
  logic ill_exp = 1'b0;

  multicycle_ctrl dut (
    .ctrl_bus     (bus),
    .op           (op),
    .funct        (funct),
    .zero         (zero),
    .i_or_d       (i_or_d),
    .ireg_enab    (ireg_enab),
    .pc_enab      (pc_enab),
    .pc_src       (pc_src),
    .alu_srcA     (alu_srcA),
    .alu_srcB     (alu_srcB),
    .alu_ctrl_sig (alu_ctrl_sig),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .jmp          (jmp),
    .mem_write    (mem_write),
    .state        (state),
    .retire       (retire),
    .illegal_op   (illegal_op)
  );

  initial bus.clk = 1'b0;
  always #5 bus.clk = ~bus.clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int latency(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int exp_state(input logic [5:0] o, input int k);
    int s[5];
    case (o)
      6'b100011: s = '{0, 1, 2, 3, 4};
      6'b101011: s = '{0, 1, 2, 5, 0};
      6'b000000: s = '{0, 1, 6, 7, 0};
      6'b001000: s = '{0, 1, 9, 10, 0};
      6'b000100: s = '{0, 1, 8, 0, 0};
      6'b000010: s = '{0, 1, 11, 0, 0};
      default:   s = '{0, 1, 0, 0, 0};
    endcase
    return s[k];
  endfunction

  function automatic logic [2:0] alu_for(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // {i_or_d, ireg_enab, pc_enab, pc_src, alu_srcA, alu_srcB, alu_ctrl, reg_dst, mem_to_reg, reg_write, jmp, mem_write}
  function automatic logic [15:0] exp_out(input int st, input logic [5:0] f, input logic z, input logic rst);
    logic pcw, br, iord, ireg, pce, pcs, sa, rd, m2r, rw, jp, mw;
    logic [1:0] sb;
    logic [2:0] alu;
    pcw  = (st == 0) || (st == 11);
    br   = (st == 8);
    iord = (st == 3) || (st == 5);
    ireg = (st == 0);
    pcs  = br;
    sa   = (st == 2) || (st == 6) || (st == 8) || (st == 9);
    sb   = (st == 0) ? 2'b01 : (st == 1) ? 2'b11 : (st == 2 || st == 9) ? 2'b10 : 2'b00;
    alu  = (st == 6) ? alu_for(f) : (st == 8) ? 3'b110 : 3'b010;
    rd   = (st == 7);
    m2r  = (st == 4);
    rw   = (st == 4) || (st == 7) || (st == 10);
    jp   = (st == 11);
    mw   = (st == 5);
    pce  = pcw | (br & z);
    if (rst) begin
      pce = 1'b0; ireg = 1'b0; rw = 1'b0; mw = 1'b0;
    end
    return {iord, ireg, pce, pcs, sa, sb, alu, rd, m2r, rw, jp, mw};
  endfunction

  function automatic logic [15:0] dut_out();
    return {i_or_d, ireg_enab, pc_enab, pc_src, alu_srcA, alu_srcB, alu_ctrl_sig,
            reg_dst, mem_to_reg, reg_write, jmp, mem_write};
  endfunction

  // Entered at #1 after a rising edge with the DUT in FETCH; leaves it the same way.
  // zmode: 0 random zero, 1 force zero=1, 2 force zero=0. rst_at: cycle index to reset in, -1 none.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode, input int rst_at);
    int lat;
    int st;
    int retires;
    lat = latency(o);
    retires = 0;
    op = o;
    funct = f;
    for (int k = 0; k < lat; k++) begin
      zero = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      st = exp_state(o, k);
      if (k == rst_at) begin
        bus.reset = 1'b1;
        #1;
        check_val("state_at_reset", 32'(state), 32'(st));
        check_val("outs_in_reset", 32'(dut_out()), 32'(exp_out(st, f, zero, 1'b1)));
        @(posedge bus.clk);
        #1;
        check_val("state_after_reset", 32'(state), 0);
        check_val("illegal_cleared", 32'(illegal_op), 0);
        ill_exp = 1'b0;
        bus.reset = 1'b0;
        $display("instr op=%b funct=%b abandoned by reset in cycle %0d", o, f, k);
        return;
      end
      #1;
      check_val("state", 32'(state), 32'(st));
      check_val("outputs", 32'(dut_out()), 32'(exp_out(st, f, zero, 1'b0)));
      check_val("retire", 32'(retire), 32'(k == lat - 1));
      check_val("illegal_op", 32'(illegal_op), 32'(ill_exp));
      if (retire) retires++;
      @(posedge bus.clk);
      #1;
      if (k == 1 && lat == 2) ill_exp = 1'b1;
    end
    check_val("retire_count", 32'(retires), 1);
    $display("instr op=%b funct=%b latency=%0d retired", o, f, lat);
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] fns[5];
    logic [5:0] o, f;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    bus.reset = 1'b1;
    op = 6'b0;
    funct = 6'b0;
    zero = 1'b1;
    repeat (2) @(posedge bus.clk);
    #1;
    check_val("reset_state", 32'(state), 0);
    check_val("reset_outs", 32'(dut_out()), 32'(exp_out(0, 6'b0, 1'b1, 1'b1)));
    check_val("reset_illegal", 32'(illegal_op), 0);
    bus.reset = 1'b0;
    #1;
    check_val("first_fetch_ireg", 32'(ireg_enab), 1);
    check_val("first_fetch_pc", 32'(pc_enab), 1);

    run_instr(6'b100011, 6'b000000, 0, -1);   // lw
    run_instr(6'b000100, 6'b000000, 1, -1);   // beq taken
    run_instr(6'b000100, 6'b000000, 2, -1);   // beq not taken
    run_instr(6'b000000, 6'b101010, 0, -1);   // slt
    run_instr(6'b000000, 6'b111111, 0, -1);   // unknown funct
    run_instr(6'b111111, 6'b000000, 0, -1);   // unsupported op
    run_instr(6'b101011, 6'b000000, 0, 3);    // sw, reset in MEMWR
    run_instr(6'b101011, 6'b000000, 0, -1);   // sw
    run_instr(6'b000010, 6'b000000, 0, -1);   // j

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 6) == 6) begin
        o = 6'($urandom);
        if (latency(o) != 2) o = 6'b110011;
      end else begin
        o = ops[$urandom_range(0, 5)];
      end
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(o, f, 0, ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, latency(o) - 1)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
